// File: rtl/fetch_rv32_pkg.sv
// fetch_rv32 shared types and constants.
// Imported by the fetch stage, its buffer and its interface.
package fetch_rv32_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

endpackage

// File: rtl/fetch_rv32_if.sv
// fetch_rv32 bus: cache request/response, redirect
// and the valid/ready hand-off to decode.
interface fetch_rv32_if;
  import fetch_rv32_pkg::*;

  logic [XLEN-1:0] oPCADDR;
  logic [XLEN-1:0] iPCDATA;
  logic            iStallI;
  logic            iBranchTaken;
  logic [XLEN-1:0] iBranchTarget;
  logic [XLEN-1:0] oInstr;
  logic [XLEN-1:0] oInstrPC;
  logic            oValid;
  logic            iReady;

  modport master (
    output oPCADDR, oInstr, oInstrPC, oValid,
    input  iPCDATA, iStallI, iBranchTaken,
    input  iBranchTarget, iReady
  );

  modport slave (
    input  oPCADDR, oInstr, oInstrPC, oValid,
    output iPCDATA, iStallI, iBranchTaken,
    output iBranchTarget, iReady
  );

endinterface

// File: rtl/fetch_buffer_rv32.sv
// Small synchronous FIFO of {pc, instr} entries
// with flush; head is the oldest entry.
module fetch_buffer_rv32
  import fetch_rv32_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output entry_t        head
);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  function automatic logic [PW-1:0] bump(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head = mem[rd_ptr];

  // Entry storage; cleared on reset so head reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; flush empties in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) rd_ptr <= bump(rd_ptr);
      if (push) wr_ptr <= bump(wr_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH)
  );

endmodule

// File: rtl/fetch_rv32.sv
// RV32 fetch stage: owns the PC, issues one cache
// read per cycle, absorbs stalls and redirects.
module fetch_rv32
  import fetch_rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int BUF_DEPTH = 2
) (
  input logic         iCLK,
  input logic         iRSTn,
  fetch_rv32_if.master bus
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int LW = CW + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight;
  logic            valid;
  logic            pop;
  logic            accept;
  logic            issue;
  logic [CW-1:0]   count;
  logic [LW-1:0]   level;
  entry_t          head;
  entry_t          push_data;
  logic            unused_tgt;

  assign unused_tgt = ^bus.iBranchTarget[1:0];

  assign valid  = (count != '0);
  assign pop    = valid && bus.iReady;
  assign accept = inflight && !bus.iStallI
               && !bus.iBranchTaken;

  // Slots already spoken for after this cycle's pop.
  assign level = {1'b0, count} + LW'(inflight)
               - LW'(pop);
  assign issue = !bus.iStallI && !bus.iBranchTaken
              && (level < LW'(BUF_DEPTH));

  assign push_data = '{pc: inflight_pc,
                       instr: bus.iPCDATA};

  assign bus.oPCADDR  = pc;
  assign bus.oValid   = valid;
  assign bus.oInstr   = head.instr;
  assign bus.oInstrPC = head.pc;

  // PC and in-flight tracking; redirect beats stall.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
    end else if (bus.iBranchTaken) begin
      pc       <= {bus.iBranchTarget[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
    end else if (issue) begin
      pc          <= pc + PC_STEP;
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight <= 1'b0;
      if (bus.iStallI && inflight) pc <= inflight_pc;
    end
  end

  fetch_buffer_rv32 #(
    .DEPTH(BUF_DEPTH)
  ) u_buf (
    .clk      (iCLK),
    .rst_n    (iRSTn),
    .push     (accept),
    .push_data(push_data),
    .pop      (pop),
    .flush    (bus.iBranchTaken),
    .count    (count),
    .head     (head)
  );

endmodule

// File: tb/tb_fetch_rv32.sv
// Bench for fetch_rv32: program-order delivery model
// plus directed stall/backpressure/redirect/reset cases.
module tb_fetch_rv32;
  import fetch_rv32_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst2_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_rv32_if bus1 ();
  fetch_rv32_if bus2 ();

  fetch_rv32 #(.RESET_PC(32'h0), .BUF_DEPTH(2)) dut (
    .iCLK(clk), .iRSTn(rst_n), .bus(bus1)
  );

  fetch_rv32 #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut2 (
    .iCLK(clk), .iRSTn(rst2_n), .bus(bus2)
  );

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a >> 2) + 32'd100;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Cache: registered read, garbage while stalled.
  logic [31:0] rd1, rd2;
  always @(posedge clk) begin
    rd1 <= word_at(bus1.oPCADDR);
    rd2 <= word_at(bus2.oPCADDR);
  end
  assign bus1.iPCDATA = bus1.iStallI ? 32'hBAD0_0BAD : rd1;
  assign bus2.iPCDATA = rd2;
  assign bus2.iStallI = 1'b0;
  assign bus2.iBranchTaken = 1'b0;
  assign bus2.iBranchTarget = 32'h0;
  assign bus2.iReady = 1'b1;

  // Model: decode must see PCs in program order,
  // restarting at the aligned target after a redirect.
  logic [31:0] exp_pc = 32'h0;
  always @(negedge clk) begin : model
    logic [31:0] nxt;
    nxt = exp_pc;
    if (!rst_n) begin
      nxt = 32'h0;
    end else begin
      if (bus1.oValid && bus1.iReady) begin
        check("deliver_pc", bus1.oInstrPC, nxt);
        check("deliver_instr", bus1.oInstr, word_at(nxt));
        nxt = nxt + 32'd4;
      end
      if (bus1.iBranchTaken)
        nxt = bus1.iBranchTarget & ~32'h3;
    end
    exp_pc <= nxt;
  end

  // Wrap instance: capture the first four deliveries.
  logic [31:0] got2_pc [$];
  logic [31:0] got2_in [$];
  always @(negedge clk) begin
    if (rst2_n && bus2.oValid && got2_pc.size() < 4) begin
      got2_pc.push_back(bus2.oInstrPC);
      got2_in.push_back(bus2.oInstr);
    end
  end

  logic [31:0] h;
  logic [31:0] wrap_pc [4];
  logic [31:0] wrap_in [4];

  initial begin
    wrap_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC,
                32'h0000_0000, 32'h0000_0004};
    wrap_in = '{32'h4000_0062, 32'h4000_0063,
                32'h0000_0064, 32'h0000_0065};
    bus1.iStallI = 1'b0;
    bus1.iBranchTaken = 1'b0;
    bus1.iBranchTarget = 32'h0;
    bus1.iReady = 1'b1;
    repeat (2) tick;
    check("rst_valid", 32'(bus1.oValid), 32'd0);
    check("rst_instr", bus1.oInstr, 32'd0);
    check("rst_instrpc", bus1.oInstrPC, 32'd0);
    check("rst_pcaddr", bus1.oPCADDR, 32'd0);
    check("rst2_pcaddr", bus2.oPCADDR, 32'hFFFF_FFF8);

    rst_n = 1'b1;
    rst2_n = 1'b1;
    check("c0_pcaddr", bus1.oPCADDR, 32'd0);
    tick;
    check("c1_pcaddr", bus1.oPCADDR, 32'd4);
    check("c1_valid", 32'(bus1.oValid), 32'd0);
    tick;
    check("c2_pcaddr", bus1.oPCADDR, 32'd8);
    check("c2_valid", 32'(bus1.oValid), 32'd1);
    check("c2_instrpc", bus1.oInstrPC, 32'd0);
    check("c2_instr", bus1.oInstr, 32'd100);
    tick;
    check("c3_pcaddr", bus1.oPCADDR, 32'd12);
    check("c3_instrpc", bus1.oInstrPC, 32'd4);

    // Stall while 0x10 is in flight.
    for (int i = 0; i < 50 && bus1.oPCADDR !== 32'h14; i++)
      tick;
    check("reach_14", bus1.oPCADDR, 32'h14);
    bus1.iStallI = 1'b1;
    repeat (3) begin
      tick;
      check("stall_pcaddr", bus1.oPCADDR, 32'h10);
      check("stall_valid", 32'(bus1.oValid), 32'd0);
    end
    bus1.iStallI = 1'b0;
    repeat (4) tick;

    // Decode backpressure.
    h = exp_pc;
    bus1.iReady = 1'b0;
    repeat (5) begin
      tick;
      check("bp_valid", 32'(bus1.oValid), 32'd1);
      check("bp_instrpc", bus1.oInstrPC, h);
      check("bp_pcaddr", bus1.oPCADDR, h + 32'd8);
    end
    check("bp_count", 32'(dut.u_buf.count), 32'd2);

    // Redirect with a full buffer.
    bus1.iBranchTarget = 32'h0000_0203;
    bus1.iBranchTaken = 1'b1;
    tick;
    bus1.iBranchTaken = 1'b0;
    check("br_valid", 32'(bus1.oValid), 32'd0);
    check("br_pcaddr", bus1.oPCADDR, 32'h200);
    bus1.iReady = 1'b1;
    tick;
    check("br_valid2", 32'(bus1.oValid), 32'd0);
    tick;
    check("br_first_pc", bus1.oInstrPC, 32'h200);
    check("br_first_v", 32'(bus1.oValid), 32'd1);

    // Redirect coinciding with a pop.
    repeat (3) tick;
    bus1.iBranchTarget = 32'h0000_1000;
    bus1.iBranchTaken = 1'b1;
    tick;
    bus1.iBranchTaken = 1'b0;
    check("brpop_pcaddr", bus1.oPCADDR, 32'h1000);
    check("brpop_valid", 32'(bus1.oValid), 32'd0);
    repeat (2) tick;
    check("brpop_first_pc", bus1.oInstrPC, 32'h1000);

    // Redirect together with a stall.
    repeat (2) tick;
    bus1.iBranchTarget = 32'h0000_0302;
    bus1.iBranchTaken = 1'b1;
    bus1.iStallI = 1'b1;
    tick;
    bus1.iBranchTaken = 1'b0;
    bus1.iStallI = 1'b0;
    check("brst_pcaddr", bus1.oPCADDR, 32'h300);
    check("brst_valid", 32'(bus1.oValid), 32'd0);
    repeat (2) tick;
    check("brst_first_pc", bus1.oInstrPC, 32'h300);

    // Asynchronous reset between edges.
    repeat (3) tick;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus1.oValid), 32'd0);
    check("arst_pcaddr", bus1.oPCADDR, 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    check("arst_first_v", 32'(bus1.oValid), 32'd1);
    check("arst_first_pc", bus1.oInstrPC, 32'd0);
    check("arst_first_in", bus1.oInstr, 32'd100);
    repeat (4) tick;

    // Wrap-around instance.
    check("wrap_count", got2_pc.size(), 32'd4);
    for (int i = 0; i < 4 && i < got2_pc.size(); i++) begin
      check("wrap_pc", got2_pc[i], wrap_pc[i]);
      check("wrap_instr", got2_in[i], wrap_in[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
